// File: rtl/spi_slave_fl_pkg.sv
// Shared SPI flash definitions: opcodes, field widths and slave FSM states.
package spi_slave_fl_pkg;

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;

    localparam logic [CMD_W-1:0]  OP_READ   = 8'h03;
    localparam logic [CMD_W-1:0]  OP_WRITE  = 8'h02;
    localparam logic [CMD_W-1:0]  OP_RDID   = 8'h9F;
    localparam logic [ADDR_W-1:0] ADDR_STEP = 24'd4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Brings sclk/ss/mosi into the clk domain and flags sclk leading/trailing edges and ss edges.
module spi_slave_sync #(
    parameter bit CPOL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic ss,
    input  logic mosi,
    output logic lead_c,
    output logic trail_c,
    output logic ss_fall_c,
    output logic ss_rise_c,
    output logic mosi_s
);

    logic [2:0] sclk_q;
    logic [2:0] ss_q;
    logic [1:0] mosi_q;
    logic [1:0] flush_cnt;
    logic       armed;

    // armed blocks the false ss fall seen when ss is already low as reset releases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q    <= {3{CPOL}};
            ss_q      <= 3'b111;
            mosi_q    <= 2'b00;
            flush_cnt <= 2'd0;
            armed     <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ss_q   <= {ss_q[1:0], ss};
            mosi_q <= {mosi_q[0], mosi};
            if (flush_cnt != 2'd3) begin
                flush_cnt <= flush_cnt + 2'd1;
            end else if (ss_q[2]) begin
                armed <= 1'b1;
            end
        end
    end

    always_comb begin
        lead_c    = (sclk_q[1] != sclk_q[2]) && (sclk_q[1] != CPOL);
        trail_c   = (sclk_q[1] != sclk_q[2]) && (sclk_q[1] == CPOL);
        ss_fall_c = armed && ss_q[2] && !ss_q[1];
        ss_rise_c = !ss_q[2] && ss_q[1];
    end

    assign mosi_s = mosi_q[1];

endmodule

// File: rtl/spi_slave_fl.sv
// SPI flash-style slave: READ/WRITE/READ ID commands bridged onto a simple word backend.
module spi_slave_fl
    import spi_slave_fl_pkg::*;
#(
    parameter bit                CPOL      = 1'b1,
    parameter bit                CPHA      = 1'b1,
    parameter logic [DATA_W-1:0] DEVICE_ID = 32'h00C22016
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              frame_done
);

    logic lead_c, trail_c, ss_fall_c, ss_rise_c, mosi_s;
    logic sample_c, shift_c;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]  sr, sr_nxt;
    logic [CMD_W-1:0]   cmd_byte;
    logic               is_read, is_read_nxt;
    logic               ren_d;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic               miso_nxt, oe_nxt, ren_nxt, wen_nxt, busy_nxt, done_nxt;

    spi_slave_sync #(.CPOL(CPOL)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .ss       (ss),
        .mosi     (mosi),
        .lead_c   (lead_c),
        .trail_c  (trail_c),
        .ss_fall_c(ss_fall_c),
        .ss_rise_c(ss_rise_c),
        .mosi_s   (mosi_s)
    );

    assign sample_c = CPHA ? trail_c : lead_c;
    assign shift_c  = CPHA ? lead_c  : trail_c;
    assign cmd_byte = {sr[CMD_W-2:0], mosi_s};

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sr_nxt      = ren_d ? mem_rdata : sr;
        is_read_nxt = is_read;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        miso_nxt    = miso;
        oe_nxt      = miso_oe;
        ren_nxt     = 1'b0;
        wen_nxt     = 1'b0;
        done_nxt    = 1'b0;

        // the write strobe goes out with the old address; advance once it has been seen
        if (mem_wen) begin
            addr_nxt = mem_addr + ADDR_STEP;
        end

        if (ss_rise_c) begin
            state_nxt = IDLE;
            miso_nxt  = 1'b0;
            oe_nxt    = 1'b0;
            done_nxt  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_fall_c) begin
                        state_nxt = CMD;
                        cnt_nxt   = '0;
                    end
                end
                CMD: begin
                    if (sample_c) begin
                        sr_nxt  = {sr[DATA_W-2:0], mosi_s};
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(CMD_W - 1)) begin
                            cnt_nxt = '0;
                            case (cmd_byte)
                                OP_READ, OP_WRITE: begin
                                    state_nxt   = ADDR;
                                    is_read_nxt = (cmd_byte == OP_READ);
                                end
                                OP_RDID: begin
                                    state_nxt   = RDATA;
                                    is_read_nxt = 1'b0;
                                    sr_nxt      = DEVICE_ID;
                                    // leading-edge sampling needs the MSB on the wire before the first data clock
                                    if (!CPHA) begin
                                        miso_nxt = DEVICE_ID[DATA_W-1];
                                        oe_nxt   = 1'b1;
                                    end
                                end
                                default: state_nxt = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sample_c) begin
                        addr_nxt = {mem_addr[ADDR_W-2:0], mosi_s};
                        cnt_nxt  = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ADDR_W - 1)) begin
                            cnt_nxt = '0;
                            if (is_read) begin
                                ren_nxt   = 1'b1;
                                state_nxt = RDATA;
                            end else begin
                                state_nxt = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (shift_c) begin
                        miso_nxt = sr[DATA_W-1];
                        oe_nxt   = 1'b1;
                        sr_nxt   = {sr[DATA_W-2:0], 1'b0};
                        cnt_nxt  = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            cnt_nxt = '0;
                            if (is_read) begin
                                addr_nxt = mem_addr + ADDR_STEP;
                                ren_nxt  = 1'b1;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sample_c) begin
                        wdata_nxt = {mem_wdata[DATA_W-2:0], mosi_s};
                        cnt_nxt   = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            cnt_nxt = '0;
                            wen_nxt = 1'b1;
                        end
                    end
                end
                IGNORE: ;
                default: state_nxt = IDLE;
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            is_read    <= 1'b0;
            ren_d      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sr         <= sr_nxt;
            is_read    <= is_read_nxt;
            ren_d      <= mem_ren;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            miso       <= miso_nxt;
            miso_oe    <= oe_nxt;
            mem_ren    <= ren_nxt;
            mem_wen    <= wen_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule
